instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
// Write-side counterpart of instruction fetch: accepts field-level instruction descriptions over a
// valid/ready handshake, packs them into 32-bit words, writes them sequentially into instruction memory.
// Also bulk-fills memory with a default word before a program load. Sits between testbench/host and the
// instruction memory write port.
// PARAMETERS
// ADDR_W        8                 instruction memory address width
// DEPTH         256               words in instruction memory (== 2**ADDR_W)
// DEFAULT_WORD  32'h0021_0820     fill pattern written by FILL
// PORTS
// clk        in   1        clock, all state on rising edge
// reset      in   1        reset, synchronous, active-high
// fill_start in   1        pulse: fill whole memory with DEFAULT_WORD, then rewind pointer
// in_valid   in   1        instruction descriptor valid
// in_ready   out  1        loader can accept descriptor this cycle
// in_fmt     in   2        0=R, 1=I, 2=J, 3=RAW
// in_opcode  in   6        opcode
// in_rd/in_rs/in_rt in 5 each   register fields
// in_shamt   in   5        shift amount (R only)
// in_funct   in   6        function code (R only)
// in_const   in   16       immediate (I only)
// in_target  in   26       jump target (J only)
// in_raw     in   32       full word (RAW only)
// in_last    in   1        descriptor is final of program
// mem_we     out  1        memory write strobe
// mem_addr   out  ADDR_W   memory write address
// mem_wdata  out  32       memory write data
// wr_count   out  ADDR_W+1 descriptors written since last IDLE entry
// busy       out  1        FILL in progress
// done       out  1        program complete (DONE state)
// full       out  1        DEPTH descriptors written
// BEHAVIOUR
// - Word layout (matches fetch decode): opcode[31:26] rd[25:21] rs[20:16] rt[15:11] shamt[10:6] funct[5:0].
//   R: all six fields. I: opcode,rd,rs in [31:16], const in [15:0]. J: opcode[31:26], target[25:0]. RAW: in_raw.
// - States IDLE, LOAD, FILL, DONE. Reset -> IDLE, ptr=0, wr_count=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   busy=0, done=0, full=0. Reset mid-FILL/LOAD aborts; no further writes; memory contents left as is.
// - in_ready=1 in IDLE and LOAD only; 0 in FILL, DONE, and in the cycle fill_start is high.
// - Accept = in_valid & in_ready at edge N: mem_we=1, mem_addr=ptr, mem_wdata=packed word during cycle N+1
//   (registered, 1-cycle latency); ptr, wr_count += 1. Back-to-back accepts give one write per cycle.
// - IDLE -> LOAD on first accept. LOAD/IDLE -> DONE when accepted descriptor has in_last=1 or ptr reaches
//   DEPTH (then full=1; ptr does not wrap). DONE holds; done=1; no writes.
// - fill_start in IDLE/LOAD/DONE -> FILL (priority over concurrent in_valid, which is not accepted).
//   fill_start ignored while in FILL. FILL: busy=1, DEPTH consecutive writes addr 0..DEPTH-1 of
//   DEFAULT_WORD, first write in cycle after fill_start; after last write -> IDLE, ptr=0, wr_count=0,
//   full=0, done=0.
// - mem_we=0 in every cycle with no write; mem_addr/mem_wdata hold last values.
// - Unused fields for a format are ignored (no effect on word).
// STRUCTURE
// - Package mips_pkg: field bit positions, fmt enum (FMT_R/I/J/RAW), loader state enum, DEFAULT_NOP.
// - Sub-module instr_packer: combinational fmt+fields -> 32-bit word; loader holds FSM, ptr, output regs.
// TESTING
// - R accept: fmt=0 op=0 rd=1 rs=1 rt=1 shamt=0 funct=0x20 -> next cycle mem_we=1 addr=0 wdata=32'h0021_0820.
// - I/J/RAW: op=0x08 rd=2 rs=3 const=0xBEEF -> 32'h2043_BEEF; J op=0x02 target=0x100 -> 32'h0800_0100;
//   RAW 0xDEADBEEF passes unchanged; addresses 0,1,2 back-to-back, wr_count=3.
// - in_last on 4th descriptor -> DONE, done=1, in_ready=0, further in_valid produces no mem_we.
// - Fill: fill_start from DONE -> busy=1 for 256 cycles, writes addr 0..255 of DEFAULT_WORD, then IDLE,
//   wr_count=0, next accept writes addr 0.
// - Full: 256 accepts without in_last -> full=1, done=1, last write addr 255, no wrap to 0.
// - Reset at fill addr 100 -> mem_we=0 next cycle, all outputs at reset values, in_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the field bit positions of the 32-bit instruction word (the same
// positions the fetch/decode side uses), the descriptor format enum, the
// loader FSM state enum and the default fill word.
package mips_pkg;

  localparam int          ADDR_W      = 8;
  localparam int          DEPTH       = 256;
  localparam logic [31:0] DEFAULT_NOP = 32'h0021_0820;

  // LSB position of each field inside the packed word.
  localparam int OPC_LSB   = 26;
  localparam int RD_LSB    = 21;
  localparam int RS_LSB    = 16;
  localparam int RT_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RAW = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: format + field values -> 32-bit instruction word.
// Ports:
//   i_fmt      descriptor format (FMT_R / FMT_I / FMT_J / FMT_RAW)
//   i_opcode, i_rd, i_rs, i_rt, i_shamt, i_funct, i_const, i_target, i_raw
//              field values; fields not used by i_fmt have no effect
//   o_word     packed instruction word
module instr_packer
  import mips_pkg::*;
(
  input  logic [1:0]  i_fmt,
  input  logic [5:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_const,
  input  logic [25:0] i_target,
  input  logic [31:0] i_raw,
  output logic [31:0] o_word
);

  logic [31:0] w_hdr;

  // opcode/rd/rs occupy the upper half for both R and I formats.
  assign w_hdr = (32'(i_opcode) << OPC_LSB) |
                 (32'(i_rd)     << RD_LSB)  |
                 (32'(i_rs)     << RS_LSB);

  always_comb begin
    o_word = '0;
    case (fmt_e'(i_fmt))
      FMT_R:   o_word = w_hdr |
                        (32'(i_rt)    << RT_LSB)    |
                        (32'(i_shamt) << SHAMT_LSB) |
                        (32'(i_funct) << FUNCT_LSB);
      FMT_I:   o_word = w_hdr | 32'(i_const);
      FMT_J:   o_word = (32'(i_opcode) << OPC_LSB) | 32'(i_target);
      default: o_word = i_raw;
    endcase
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction memory loader. Accepts field-level instruction descriptors
// over a valid/ready handshake, packs them and writes them to consecutive
// instruction-memory addresses; can also bulk-fill the whole memory with
// DEFAULT_WORD.
// Handshake: a descriptor is transferred on a rising edge where
// in_valid && in_ready; in_ready does not depend on in_valid, and the
// source must hold its fields stable while in_valid is high and not taken.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   fill_start            pulse: fill memory with DEFAULT_WORD, then rewind
//   in_valid/in_ready     descriptor handshake
//   in_fmt .. in_raw      descriptor fields, in_last marks the final one
//   mem_we/addr/wdata     registered memory write port (1-cycle latency)
//   wr_count              descriptors written since pointer rewind
//   busy / done / full    fill running / program complete / memory full
//   state_dbg             current FSM state (ld_state_e encoding)
module instruction_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_W       = mips_pkg::ADDR_W,
  parameter int          DEPTH        = mips_pkg::DEPTH,
  parameter logic [31:0] DEFAULT_WORD = DEFAULT_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_const,
  input  logic [25:0]       in_target,
  input  logic [31:0]       in_raw,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  ld_state_e         r_state;
  logic [ADDR_W:0]   r_ptr;        // next descriptor address, doubles as wr_count
  logic [ADDR_W:0]   r_fill_addr;  // next fill address; DEPTH means fill finished
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_full;

  logic [31:0]       w_word;
  logic              w_can_take;
  logic              w_accept;
  logic              w_last_slot;

  instr_packer u_packer (
    .i_fmt    (in_fmt),
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .i_shamt  (in_shamt),
    .i_funct  (in_funct),
    .i_const  (in_const),
    .i_target (in_target),
    .i_raw    (in_raw),
    .o_word   (w_word)
  );

  // fill_start wins over a concurrent descriptor, so it blocks ready.
  assign w_can_take  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign in_ready    = w_can_take & ~fill_start;
  assign w_accept    = in_valid & in_ready;
  assign w_last_slot = (r_ptr == LP_DEPTH - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_fill_addr <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD, ST_DONE: begin
          if (fill_start) begin
            // Address 0 is written right away so the fill occupies exactly
            // DEPTH cycles starting the cycle after fill_start.
            r_state     <= ST_FILL;
            r_busy      <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= DEFAULT_WORD;
            r_fill_addr <= (ADDR_W+1)'(1);
          end else if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr[ADDR_W-1:0];
            r_mem_wdata <= w_word;
            r_ptr       <= r_ptr + 1'b1;
            if (in_last || w_last_slot) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              if (w_last_slot) r_full <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_FILL: begin
          if (r_fill_addr == LP_DEPTH) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_fill_addr[ADDR_W-1:0];
            r_mem_wdata <= DEFAULT_WORD;
            r_fill_addr <= r_fill_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wr_count  = r_ptr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign full      = r_full;
  assign state_dbg = r_state;

endmodule
